// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, held instruction towards decode,
// and the retire-time control/datapath inputs that steer the next PC.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        Zero;
  logic [31:0] rs_data;
  logic        err;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr, inst, OpCode, Funct, inst_valid,
           pc_out, pc_plus4, err, instret,
    input  imem_ready, imem_rdata, inst_ready, PCSrc, Branch, Zero, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, inst, OpCode, Funct, inst_valid,
           pc_out, pc_plus4, err, instret,
    output imem_ready, imem_rdata, inst_ready, PCSrc, Branch, Zero, rs_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter and single-outstanding instruction fetch; holds each word for decode
// and computes the next PC from control/ALU inputs on the retire edge.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  instruction_fetch_if.master bus
);

  localparam logic [1:0] ST_RST_WAIT = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        misaligned_s;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] word);
    jump_target = {pc4[31:28], word[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    branch_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign pc_plus4_s   = pc_q + 32'd4;
  assign misaligned_s = (bus.PCSrc == 2'b10) && (bus.rs_data[1:0] != 2'b00);

  // Next-PC select; only consumed on the retire edge. PCSrc=11 falls back to sequential/branch.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (bus.PCSrc)
      2'b01: next_pc_s = jump_target(pc_plus4_s, inst_q);
      2'b10: next_pc_s = bus.rs_data;
      default: begin
        if (bus.Branch && bus.Zero) begin
          next_pc_s = branch_target(pc_plus4_s, inst_q[15:0]);
        end else begin
          next_pc_s = pc_plus4_s;
        end
      end
    endcase
  end

  // Fetch/issue sequencing and architectural state updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    err_d     = err_q;
    case (state_q)
      ST_RST_WAIT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ready) begin
          inst_d  = bus.imem_rdata;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (bus.inst_ready) begin
          instret_d = instret_q + 32'd1;
          pc_d      = next_pc_s;
          if (misaligned_s) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST_WAIT;
      end
    endcase
  end

  // State registers; reset also drops any memory response arriving on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST_WAIT;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0000;
      instret_q <= 32'h0000_0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.inst_valid = (state_q == ST_ISSUE);
  assign bus.imem_addr  = pc_q;
  assign bus.pc_out     = pc_q;
  assign bus.pc_plus4   = pc_plus4_s;
  assign bus.inst       = inst_q;
  assign bus.OpCode     = inst_q[31:26];
  assign bus.Funct      = inst_q[5:0];
  assign bus.err        = err_q;
  assign bus.instret    = instret_q;

  instruction_fetch_checker u_checker (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (bus.imem_req),
    .imem_ready (bus.imem_ready),
    .imem_addr  (bus.imem_addr),
    .inst_valid (bus.inst_valid),
    .err        (bus.err)
  );

endmodule

// Protocol invariants of the fetch handshake.
module instruction_fetch_checker (
  input logic        clk,
  input logic        reset,
  input logic        imem_req,
  input logic        imem_ready,
  input logic [31:0] imem_addr,
  input logic        inst_valid,
  input logic        err
);

  a_req_valid_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(imem_req && inst_valid));

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

  a_err_sticky: assert property (@(posedge clk) disable iff (reset)
    err |=> err);

endmodule
